// File: rtl/fwd_source_scoreboard.sv
// fwd_source_scoreboard: tracks EXE/MEM/WB destinations, publishes forwarding records, detects load-use and memory-wait stalls
module fwd_source_scoreboard #(
   parameter int RBUS     = 32,
   parameter int RADDR    = 4,
   parameter int ZERO_REG = 1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             dec_valid,
   input  logic             dec_we,
   input  logic             dec_is_load,
   input  logic [RADDR-1:0] dec_rd,
   input  logic [RADDR-1:0] dec_rs,
   input  logic [RADDR-1:0] dec_rx,
   input  logic             dec_use_rs,
   input  logic             dec_use_rx,
   input  logic             flush,
   input  logic [RBUS-1:0]  exe_result,
   input  logic [RBUS-1:0]  mem_result,
   input  logic [RBUS-1:0]  wb_result,
   input  logic             mem_ready,
   output logic             fw_exe_en,
   output logic [RADDR-1:0] fw_exe_rd,
   output logic [RBUS-1:0]  fw_exe_data,
   output logic             fw_mem_en,
   output logic [RADDR-1:0] fw_mem_rd,
   output logic [RBUS-1:0]  fw_mem_data,
   output logic             fw_wb_en,
   output logic [RADDR-1:0] fw_wb_rd,
   output logic [RBUS-1:0]  fw_wb_data,
   output logic             stall_dec,
   output logic             freeze,
   output logic [CNT_W-1:0] stall_cnt
);
   typedef struct packed {
      logic             valid;
      logic             we;
      logic             is_load;
      logic [RADDR-1:0] rd;
   } ent_t;

   ent_t             e_q, e_d, m_q, m_d, w_q, w_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hazard;

   function automatic logic live(input ent_t x);
      return x.valid & x.we & !((ZERO_REG != 0) && (x.rd == '0));
   endfunction

   // hazard/stall detection, forwarding records and next pipeline state
   always_comb begin
      freeze      = m_q.valid & m_q.is_load & ~mem_ready;
      hazard      = dec_valid & live(e_q) & e_q.is_load &
                    ((dec_use_rs & (dec_rs == e_q.rd)) | (dec_use_rx & (dec_rx == e_q.rd)));
      stall_dec   = freeze | (hazard & ~flush);
      fw_exe_en   = live(e_q) & ~e_q.is_load;
      fw_exe_rd   = e_q.rd;
      fw_exe_data = exe_result;
      fw_mem_en   = live(m_q) & ~freeze;
      fw_mem_rd   = m_q.rd;
      fw_mem_data = mem_result;
      fw_wb_en    = live(w_q);
      fw_wb_rd    = w_q.rd;
      fw_wb_data  = wb_result;
      stall_cnt   = cnt_q;
      e_d         = e_q;
      m_d         = m_q;
      w_d         = w_q;
      if (!freeze) begin
         w_d = m_q;
         m_d = e_q;
         e_d = (flush | hazard | ~dec_valid) ? '0 : {1'b1, dec_we, dec_is_load, dec_rd};
      end
      cnt_d       = (stall_dec && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
   end

   // stage entries and stall counter, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_q   <= '0;
         m_q   <= '0;
         w_q   <= '0;
         cnt_q <= '0;
      end else begin
         e_q   <= e_d;
         m_q   <= m_d;
         w_q   <= w_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: tb/tb_fwd_source_scoreboard.sv
// tb_fwd_source_scoreboard: directed scoreboard bench for the forwarding source scoreboard
module tb_fwd_source_scoreboard;
   logic        clk = 1'b0, rst = 1'b1;
   logic        dec_valid = 0, dec_we = 0, dec_is_load = 0, dec_use_rs = 0, dec_use_rx = 0, flush = 0;
   logic [3:0]  dec_rd = 0, dec_rs = 0, dec_rx = 0;
   logic [31:0] exe_result = 32'hE000_0001, mem_result = 32'hA000_0002, wb_result = 32'hB000_0003;
   logic        mem_ready = 1'b1;
   logic        fw_exe_en, fw_mem_en, fw_wb_en, stall_dec, freeze;
   logic [3:0]  fw_exe_rd, fw_mem_rd, fw_wb_rd;
   logic [31:0] fw_exe_data, fw_mem_data, fw_wb_data;
   logic [15:0] stall_cnt;
   int          errors = 0, checks = 0;

   typedef struct {
      logic ee; int er; logic me; int mr; logic we; int wr; logic sd; logic fz; int cnt;
   } exp_t;
   exp_t q[$];

   fwd_source_scoreboard dut (
      .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_we(dec_we), .dec_is_load(dec_is_load),
      .dec_rd(dec_rd), .dec_rs(dec_rs), .dec_rx(dec_rx), .dec_use_rs(dec_use_rs), .dec_use_rx(dec_use_rx),
      .flush(flush), .exe_result(exe_result), .mem_result(mem_result), .wb_result(wb_result),
      .mem_ready(mem_ready), .fw_exe_en(fw_exe_en), .fw_exe_rd(fw_exe_rd), .fw_exe_data(fw_exe_data),
      .fw_mem_en(fw_mem_en), .fw_mem_rd(fw_mem_rd), .fw_mem_data(fw_mem_data), .fw_wb_en(fw_wb_en),
      .fw_wb_rd(fw_wb_rd), .fw_wb_data(fw_wb_data), .stall_dec(stall_dec), .freeze(freeze),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, we, ld, input int rd, rs, rx, input logic urs, urx, fl);
      dec_valid = v; dec_we = we; dec_is_load = ld;
      dec_rd = 4'(rd); dec_rs = 4'(rs); dec_rx = 4'(rx);
      dec_use_rs = urs; dec_use_rx = urx; flush = fl;
      exe_result = exe_result + 32'h11; mem_result = mem_result + 32'h22; wb_result = wb_result + 32'h33;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic expect_o(input logic ee, input int er, input logic me, input int mr,
                           input logic we, input int wr, input logic sd, fz, input int cnt);
      exp_t x;
      x.ee = ee; x.er = er; x.me = me; x.mr = mr; x.we = we; x.wr = wr; x.sd = sd; x.fz = fz; x.cnt = cnt;
      q.push_back(x);
   endtask

   task automatic compare_now();
      exp_t x;
      if (q.size() == 0) begin
         checks++; errors++;
         $error("FAIL scoreboard_empty: got 0 entries expected 1");
         return;
      end
      x = q.pop_front();
      chk("fw_exe_en", 32'(fw_exe_en), 32'(x.ee));
      chk("fw_mem_en", 32'(fw_mem_en), 32'(x.me));
      chk("fw_wb_en", 32'(fw_wb_en), 32'(x.we));
      if (x.ee) chk("fw_exe_rd", 32'(fw_exe_rd), 32'(x.er));
      if (x.me) chk("fw_mem_rd", 32'(fw_mem_rd), 32'(x.mr));
      if (x.we) chk("fw_wb_rd", 32'(fw_wb_rd), 32'(x.wr));
      chk("stall_dec", 32'(stall_dec), 32'(x.sd));
      chk("freeze", 32'(freeze), 32'(x.fz));
      chk("stall_cnt", 32'(stall_cnt), 32'(x.cnt));
      chk("fw_exe_data", fw_exe_data, exe_result);
      chk("fw_mem_data", fw_mem_data, mem_result);
      chk("fw_wb_data", fw_wb_data, wb_result);
   endtask

   task automatic tick();
      @(negedge clk);
      compare_now();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset state
      idle();
      expect_o(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      rst = 1'b0;
      // 1: ADD r3 then SUB r4 using r3
      drive(1, 1, 0, 3, 0, 0, 0, 0, 0); expect_o(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      drive(1, 1, 0, 4, 3, 0, 1, 0, 0); expect_o(1, 3, 0, 0, 0, 0, 0, 0, 0); tick();
      idle(); expect_o(1, 4, 1, 3, 0, 0, 0, 0, 0); tick();
      idle(); expect_o(0, 0, 1, 4, 1, 3, 0, 0, 0); tick();
      idle(); expect_o(0, 0, 0, 0, 1, 4, 0, 0, 0); tick();
      idle(); expect_o(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      // 2: LD r5 then ADD r1,r5 -> one stall cycle
      drive(1, 1, 1, 5, 0, 0, 0, 0, 0); expect_o(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      drive(1, 1, 0, 1, 2, 5, 0, 1, 0); expect_o(0, 0, 0, 0, 0, 0, 1, 0, 0); tick();
      drive(1, 1, 0, 1, 2, 5, 0, 1, 0); expect_o(0, 0, 1, 5, 0, 0, 0, 0, 1); tick();
      idle(); expect_o(1, 1, 0, 0, 1, 5, 0, 0, 1); tick();
      idle(); expect_o(0, 0, 1, 1, 0, 0, 0, 0, 1); tick();
      idle(); expect_o(0, 0, 0, 0, 1, 1, 0, 0, 1); tick();
      // 3: LD r5 waits 3 cycles in MEM
      drive(1, 1, 1, 5, 0, 0, 0, 0, 0); expect_o(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
      idle(); expect_o(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 0, 6, 0, 0, 0, 0, 0); expect_o(0, 0, 0, 5, 0, 0, 1, 1, 1 + i); tick();
      end
      mem_ready = 1'b1;
      drive(1, 1, 0, 6, 0, 0, 0, 0, 0); expect_o(0, 0, 1, 5, 0, 0, 0, 0, 4); tick();
      idle(); expect_o(1, 6, 0, 0, 1, 5, 0, 0, 4); tick();
      idle(); expect_o(0, 0, 1, 6, 0, 0, 0, 0, 4); tick();
      idle(); expect_o(0, 0, 0, 0, 1, 6, 0, 0, 4); tick();
      // 4: hazard pair with flush in the stall cycle
      drive(1, 1, 1, 7, 0, 0, 0, 0, 0); expect_o(0, 0, 0, 0, 0, 0, 0, 0, 4); tick();
      drive(1, 1, 0, 2, 7, 0, 1, 0, 1); expect_o(0, 0, 0, 0, 0, 0, 0, 0, 4); tick();
      idle(); expect_o(0, 0, 1, 7, 0, 0, 0, 0, 4); tick();
      idle(); expect_o(0, 0, 0, 0, 1, 7, 0, 0, 4); tick();
      // 5: LD r0 then use r0 -> no stall, nothing forwarded
      drive(1, 1, 1, 0, 0, 0, 0, 0, 0); expect_o(0, 0, 0, 0, 0, 0, 0, 0, 4); tick();
      drive(1, 1, 0, 1, 0, 0, 1, 0, 0); expect_o(0, 0, 0, 0, 0, 0, 0, 0, 4); tick();
      idle(); expect_o(1, 1, 0, 0, 0, 0, 0, 0, 4); tick();
      idle(); expect_o(0, 0, 1, 1, 0, 0, 0, 0, 4); tick();
      idle(); expect_o(0, 0, 0, 0, 1, 1, 0, 0, 4); tick();
      // 5b: saturate the stall counter through a long memory wait
      drive(1, 1, 1, 8, 0, 0, 0, 0, 0); expect_o(0, 0, 0, 0, 0, 0, 0, 0, 4); tick();
      idle(); expect_o(0, 0, 0, 0, 0, 0, 0, 0, 4); tick();
      mem_ready = 1'b0;
      for (int i = 0; i < 65540; i++) @(posedge clk);
      #1;
      idle(); expect_o(0, 0, 0, 8, 0, 0, 1, 1, 16'hFFFF); tick();
      idle(); expect_o(0, 0, 0, 8, 0, 0, 1, 1, 16'hFFFF); tick();
      // 6: asynchronous reset in the middle of the freeze
      #2;
      rst = 1'b1;
      #1;
      expect_o(0, 0, 0, 0, 0, 0, 0, 0, 0);
      compare_now();
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      drive(1, 1, 0, 9, 0, 0, 0, 0, 0); expect_o(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      idle(); expect_o(1, 9, 0, 0, 0, 0, 0, 0, 0); tick();
      idle(); expect_o(0, 0, 1, 9, 0, 0, 0, 0, 0); tick();
      mem_ready = 1'b1;
      idle(); expect_o(0, 0, 0, 0, 1, 9, 0, 0, 0); tick();
      if (q.size() != 0) begin
         checks++; errors++;
         $error("FAIL scoreboard_leftover: got %0d entries expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
